// File: rtl/lau_pkg.sv
// Shared types for the arithmetic library.
package lau_pkg;

  // Implementation choice for prefix-based arithmetic cells.
  typedef enum logic {
    SLOW = 1'b0,
    FAST = 1'b1
  } speed_e;

endpackage

// File: rtl/IncDecC.sv
// Combinational incrementer/decrementer. With CI=0 it passes A through.
// With CI=1 it adds one (DEC=0) or subtracts one (DEC=1).
// CO reports the carry out of all-ones or the borrow out of zero.
module IncDecC
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] A,
  input  logic             CI,
  input  logic             DEC,
  output logic [width-1:0] Z,
  output logic             CO
);

  localparam int levels = $clog2(width);

  // Bit i toggles when every lower bit is 1 (increment) or 0 (decrement).
  // The decrement case is the same problem on inverted bits.
  logic [width-1:0] t;
  logic [width-1:0] pre;
  logic [width-1:0] lvl [0:levels];
  logic             acc;

  // Select the propagate bits for the requested direction.
  always_comb t = DEC ? ~A : A;

  // Inclusive AND-prefix of t: a log-depth tree for FAST, a ripple chain for SLOW.
  always_comb begin
    for (int l = 0; l <= levels; l++) lvl[l] = '0;
    pre = '0;
    acc = 1'b1;
    if (speed == FAST) begin
      lvl[0] = t;
      for (int l = 0; l < levels; l++) begin
        for (int i = 0; i < width; i++) begin
          if (i >= (1 << l)) lvl[l+1][i] = lvl[l][i] & lvl[l][i-(1<<l)];
          else               lvl[l+1][i] = lvl[l][i];
        end
      end
      pre = lvl[levels];
    end else begin
      for (int i = 0; i < width; i++) begin
        acc    = acc & t[i];
        pre[i] = acc;
      end
    end
  end

  // Toggle each bit whose lower bits all propagate; the full prefix is the carry/borrow.
  always_comb begin
    Z[0] = A[0] ^ CI;
    for (int i = 1; i < width; i++) Z[i] = A[i] ^ (CI & pre[i-1]);
    CO = CI & pre[width-1];
  end

endmodule

// File: rtl/incdec_counter.sv
// Registered loadable up/down counter with a wrap or saturate policy,
// zero/max status, sticky overflow/underflow and a terminal-count pulse.
module incdec_counter
  import lau_pkg::*;
#(
  parameter int     width    = 8,
  parameter speed_e speed    = FAST,
  parameter bit     saturate = 1'b0,
  parameter int     rst_val  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic             INC,
  input  logic             DEC,
  input  logic             CLR_FLAGS,
  output logic [width-1:0] Q,
  output logic             ZERO,
  output logic             MAX,
  output logic             TC,
  output logic             OVF,
  output logic             UNF
);

  localparam logic [width-1:0] rst_q = width'(rst_val);

  logic             step;
  logic             step_dec;
  logic [width-1:0] z;
  logic             co;
  logic             wrap_ev;
  logic             ovf_set;
  logic             unf_set;
  logic [width-1:0] q_nxt;

  // INC and DEC together cancel out and are treated as a hold.
  always_comb begin
    step     = INC ^ DEC;
    step_dec = DEC & ~INC;
  end

  IncDecC #(
    .width (width),
    .speed (speed)
  ) u_incdec (
    .A   (Q),
    .CI  (step),
    .DEC (step_dec),
    .Z   (z),
    .CO  (co)
  );

  // Wrap/saturate events; a step masked by CLR or LD never raises a flag.
  always_comb begin
    wrap_ev = step & co & ~CLR & ~LD;
    ovf_set = wrap_ev & ~step_dec;
    unf_set = wrap_ev & step_dec;
  end

  // Next-state mux: CLR over LD over step; saturation blocks only the wrapping step.
  always_comb begin
    q_nxt = Q;
    if (CLR)                         q_nxt = '0;
    else if (LD)                     q_nxt = D;
    else if (step && !(co && saturate)) q_nxt = z;
  end

  // State register; a set event beats a simultaneous CLR_FLAGS.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q   <= rst_q;
      TC  <= 1'b0;
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else begin
      Q   <= q_nxt;
      TC  <= wrap_ev;
      OVF <= ovf_set | (OVF & ~CLR_FLAGS);
      UNF <= unf_set | (UNF & ~CLR_FLAGS);
    end
  end

  // Status decode straight from the registered count.
  always_comb begin
    ZERO = ~|Q;
    MAX  = &Q;
  end

endmodule

// File: tb/tb_incdec_counter.sv
// Directed and randomized checks of incdec_counter across policies and widths.
module tb_incdec_counter;
  import lau_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clr = 1'b0, ld = 1'b0, inc = 1'b0, dec = 1'b0, cf = 1'b0;
  logic [16:0] d = '0;

  always #5 clk = ~clk;

  // width 4 wrap, width 4 saturate, width 4 wrap with rst_val 9
  logic [3:0]  q_w, q_s, q_r;
  logic        z_w, m_w, tc_w, ovf_w, unf_w;
  logic        z_s, m_s, tc_s, ovf_s, unf_s;
  logic        z_r, m_r, tc_r, ovf_r, unf_r;
  // random-regression instances: widths 2, 8, 17
  logic [1:0]  q_2;
  logic [7:0]  q_8;
  logic [16:0] q_17;
  logic        z_2, m_2, tc_2, ovf_2, unf_2;
  logic        z_8, m_8, tc_8, ovf_8, unf_8;
  logic        z_17, m_17, tc_17, ovf_17, unf_17;

  incdec_counter #(.width(4), .speed(FAST), .saturate(1'b0), .rst_val(0)) dut_w (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .D(d[3:0]), .INC(inc), .DEC(dec), .CLR_FLAGS(cf),
    .Q(q_w), .ZERO(z_w), .MAX(m_w), .TC(tc_w), .OVF(ovf_w), .UNF(unf_w));
  incdec_counter #(.width(4), .speed(FAST), .saturate(1'b1), .rst_val(0)) dut_s (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .D(d[3:0]), .INC(inc), .DEC(dec), .CLR_FLAGS(cf),
    .Q(q_s), .ZERO(z_s), .MAX(m_s), .TC(tc_s), .OVF(ovf_s), .UNF(unf_s));
  incdec_counter #(.width(4), .speed(FAST), .saturate(1'b0), .rst_val(9)) dut_r (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .D(d[3:0]), .INC(inc), .DEC(dec), .CLR_FLAGS(cf),
    .Q(q_r), .ZERO(z_r), .MAX(m_r), .TC(tc_r), .OVF(ovf_r), .UNF(unf_r));
  incdec_counter #(.width(2), .speed(FAST), .saturate(1'b1), .rst_val(0)) dut_2 (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .D(d[1:0]), .INC(inc), .DEC(dec), .CLR_FLAGS(cf),
    .Q(q_2), .ZERO(z_2), .MAX(m_2), .TC(tc_2), .OVF(ovf_2), .UNF(unf_2));
  incdec_counter #(.width(8), .speed(SLOW), .saturate(1'b0), .rst_val(0)) dut_8 (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .D(d[7:0]), .INC(inc), .DEC(dec), .CLR_FLAGS(cf),
    .Q(q_8), .ZERO(z_8), .MAX(m_8), .TC(tc_8), .OVF(ovf_8), .UNF(unf_8));
  incdec_counter #(.width(17), .speed(FAST), .saturate(1'b1), .rst_val(0)) dut_17 (
    .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .D(d), .INC(inc), .DEC(dec), .CLR_FLAGS(cf),
    .Q(q_17), .ZERO(z_17), .MAX(m_17), .TC(tc_17), .OVF(ovf_17), .UNF(unf_17));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; clr = 0; ld = 0; inc = 0; dec = 0; cf = 0; d = '0;
  endtask

  typedef struct {
    logic       rst, clr, ld;
    logic [3:0] d;
    logic       inc, dec, cf;
    logic [3:0] q;
    logic       tc, ovf, unf;
  } vec_t;

  function automatic vec_t mk(logic r, logic c, logic l, logic [3:0] dd, logic i, logic de,
                              logic f, logic [3:0] q, logic t, logic o, logic u);
    vec_t v;
    v.rst = r; v.clr = c; v.ld = l; v.d = dd; v.inc = i; v.dec = de; v.cf = f;
    v.q = q; v.tc = t; v.ovf = o; v.unf = u;
    return v;
  endfunction

  vec_t tv[18];

  // random-regression model state
  int     wv[3] = '{2, 8, 17};
  bit     sv[3] = '{1'b1, 1'b0, 1'b1};
  longint mq[3];
  bit     mtc[3], movf[3], munf[3];
  longint aq[3];
  logic [4:0] af[3];

  initial begin
    //              rst clr ld d    inc dec cf   q   tc ovf unf
    tv[0]  = mk(1, 0, 0, 4'd0,  0, 0, 0,  4'd0,  0, 0, 0);
    tv[1]  = mk(0, 0, 0, 4'd0,  0, 1, 0,  4'd15, 1, 0, 1);
    tv[2]  = mk(0, 0, 0, 4'd0,  0, 0, 1,  4'd15, 0, 0, 0);
    tv[3]  = mk(0, 0, 1, 4'd7,  0, 0, 0,  4'd7,  0, 0, 0);
    tv[4]  = mk(0, 0, 0, 4'd0,  1, 1, 0,  4'd7,  0, 0, 0);
    tv[5]  = mk(0, 0, 1, 4'd3,  1, 0, 0,  4'd3,  0, 0, 0);
    tv[6]  = mk(0, 0, 0, 4'd0,  1, 0, 0,  4'd4,  0, 0, 0);
    tv[7]  = mk(0, 0, 0, 4'd0,  0, 1, 0,  4'd3,  0, 0, 0);
    tv[8]  = mk(0, 1, 0, 4'd0,  0, 1, 0,  4'd0,  0, 0, 0);
    tv[9]  = mk(0, 1, 0, 4'd0,  0, 1, 0,  4'd0,  0, 0, 0);
    tv[10] = mk(0, 0, 0, 4'd0,  0, 1, 0,  4'd15, 1, 0, 1);
    tv[11] = mk(0, 1, 0, 4'd0,  0, 1, 0,  4'd0,  0, 0, 1);
    tv[12] = mk(0, 0, 1, 4'd15, 0, 0, 0,  4'd15, 0, 0, 1);
    tv[13] = mk(0, 0, 0, 4'd0,  1, 0, 1,  4'd0,  1, 1, 0);
    tv[14] = mk(0, 0, 0, 4'd0,  0, 0, 0,  4'd0,  0, 1, 0);
    tv[15] = mk(0, 0, 0, 4'd0,  0, 0, 1,  4'd0,  0, 0, 0);
    tv[16] = mk(0, 0, 0, 4'd0,  0, 1, 1,  4'd15, 1, 0, 1);
    tv[17] = mk(0, 0, 1, 4'd15, 1, 0, 0,  4'd15, 0, 0, 1);

    idle();
    #2;

    // Table vectors on the width-4 wrapping counter.
    for (int k = 0; k < 18; k++) begin
      rst = tv[k].rst; clr = tv[k].clr; ld = tv[k].ld; d = {13'd0, tv[k].d};
      inc = tv[k].inc; dec = tv[k].dec; cf = tv[k].cf;
      tick();
      chk($sformatf("vec%0d.q", k),    q_w,   tv[k].q);
      chk($sformatf("vec%0d.tc", k),   tc_w,  tv[k].tc);
      chk($sformatf("vec%0d.ovf", k),  ovf_w, tv[k].ovf);
      chk($sformatf("vec%0d.unf", k),  unf_w, tv[k].unf);
      chk($sformatf("vec%0d.zero", k), z_w,   (tv[k].q == 4'd0));
      chk($sformatf("vec%0d.max", k),  m_w,   (tv[k].q == 4'd15));
    end

    // Twenty increments from reset: wrap after 15, single TC pulse, OVF sticks.
    idle(); rst = 1; tick(); rst = 0;
    inc = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("run%0d.q", i),   q_w,   i % 16);
      chk($sformatf("run%0d.tc", i),  tc_w,  (i == 16));
      chk($sformatf("run%0d.ovf", i), ovf_w, (i >= 16));
    end

    // Saturating: load 14, three increments clamp at 15 with TC on steps 2 and 3.
    idle(); rst = 1; tick(); rst = 0;
    ld = 1; d = 17'd14; tick(); ld = 0;
    chk("sat.ld", q_s, 14);
    inc = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("sat%0d.q", i),   q_s,   15);
      chk($sformatf("sat%0d.tc", i),  tc_s,  (i >= 2));
      chk($sformatf("sat%0d.ovf", i), ovf_s, (i >= 2));
      chk($sformatf("sat%0d.max", i), m_s,   1);
    end
    // Saturating decrement at zero holds 0 and sets UNF.
    idle(); rst = 1; tick(); rst = 0;
    dec = 1; tick(); dec = 0;
    chk("satdec.q", q_s, 0);
    chk("satdec.unf", unf_s, 1);
    chk("satdec.tc", tc_s, 1);
    chk("satdec.zero", z_s, 1);
    tick();
    chk("satdec.tc_off", tc_s, 0);

    // rst_val 9: reset with a wrapping INC pending discards the step.
    idle(); rst = 1; tick(); rst = 0;
    chk("rv.reset_q", q_r, 9);
    chk("rv.reset_zero", z_r, 0);
    ld = 1; d = 17'd14; tick(); ld = 0;
    inc = 1; tick();
    chk("rv.at15", q_r, 15);
    rst = 1; tick();
    chk("rv.rst_q", q_r, 9);
    chk("rv.rst_tc", tc_r, 0);
    chk("rv.rst_ovf", ovf_r, 0);
    idle();

    // Random regression against a behavioural model for widths 2, 8, 17.
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; mtc[k] = 0; movf[k] = 0; munf[k] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      int r;
      int rd;
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      clr = (r >= 2 && r < 5);
      ld  = (r >= 5 && r < 12);
      rd  = $urandom_range(0, 3);
      d   = (rd == 0) ? 17'h1ffff : (rd == 1) ? 17'h1fffe : 17'($urandom);
      inc = ($urandom_range(0, 2) != 0);
      dec = ($urandom_range(0, 2) == 0);
      cf  = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 3; k++) begin
        longint mask;
        bit so, su;
        mask = (longint'(1) << wv[k]) - 1;
        so = 0; su = 0;
        if (rst) begin
          mq[k] = 0; mtc[k] = 0; movf[k] = 0; munf[k] = 0;
        end else begin
          mtc[k] = 0;
          if (clr)      mq[k] = 0;
          else if (ld)  mq[k] = longint'(d) & mask;
          else if (inc && !dec) begin
            if (mq[k] == mask) begin
              mtc[k] = 1; so = 1;
              mq[k] = sv[k] ? mask : 0;
            end else mq[k] = mq[k] + 1;
          end else if (dec && !inc) begin
            if (mq[k] == 0) begin
              mtc[k] = 1; su = 1;
              mq[k] = sv[k] ? 0 : mask;
            end else mq[k] = mq[k] - 1;
          end
          movf[k] = so | (movf[k] & !cf);
          munf[k] = su | (munf[k] & !cf);
        end
      end
      tick();
      aq[0] = q_2;  af[0] = {tc_2, ovf_2, unf_2, z_2, m_2};
      aq[1] = q_8;  af[1] = {tc_8, ovf_8, unf_8, z_8, m_8};
      aq[2] = q_17; af[2] = {tc_17, ovf_17, unf_17, z_17, m_17};
      for (int k = 0; k < 3; k++) begin
        longint mask;
        mask = (longint'(1) << wv[k]) - 1;
        chk($sformatf("rnd_w%0d_c%0d.q", wv[k], c), aq[k], mq[k]);
        chk($sformatf("rnd_w%0d_c%0d.flags", wv[k], c), af[k],
            {mtc[k], movf[k], munf[k], (mq[k] == 0), (mq[k] == mask)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/incdec_counter.md
# incdec_counter

Registered, loadable up/down counter for the arithmetic library. It uses `IncDecC` as its next-state datapath and adds:
- load, clear and hold control;
- a selectable wrap or saturate policy;
- zero/max status flags;
- sticky overflow/underflow flags and a terminal-count pulse.

It is intended for occupancy/credit tracking, loop counters and address generators elsewhere in the design.

## Interface
Parameters:
- `width`, 8: counter word width, ≥ 2.
- `speed`, `lau_pkg::FAST`: passed unchanged to `IncDecC`.
- `saturate`, 0: 0 = wrap modulo 2^width; 1 = clamp at 0 and 2^width−1.
- `rst_val`, 0: value of `Q` after reset; must fit in `width` bits.

Ports:
- `CLK` input 1: clock; all state updates on rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `CLR` input 1: synchronous clear of `Q` to 0.
- `LD` input 1: load `D` into `Q`.
- `D` input width: load value.
- `INC` input 1: increment request (+1).
- `DEC` input 1: decrement request (−1).
- `CLR_FLAGS` input 1: clear sticky `OVF`/`UNF`.
- `Q` output width: counter value (registered).
- `ZERO` output 1: `Q == 0`.
- `MAX` output 1: `Q == 2^width−1`.
- `TC` output 1: registered one-cycle pulse on wrap or saturation event.
- `OVF` output 1: sticky; an increment was attempted at `MAX`.
- `UNF` output 1: sticky; a decrement was attempted at `ZERO`.

## Operation
Per-cycle priority, highest first:
1. `RST`: `Q`=`rst_val`, `OVF`=`UNF`=`TC`=0.
2. `CLR`: `Q`=0, `TC`=0; flags follow the rules below.
3. `LD`: `Q`=`D`, `TC`=0.
4. `INC` xor `DEC`: step by one.
5. Otherwise, including `INC`&`DEC`: hold, `TC`=0, no flag change.

Datapath to `IncDecC`:
- `A`=`Q`, `CI`=`INC`^`DEC`, `DEC`=`DEC`&~`INC`.
- `CO`=1 on increment from all-ones (carry) and on decrement from zero (borrow).
- Stepping is blocked only when `CO`=1 and `saturate`=1.

Step rules:
- Carry or borrow, `saturate`=0: `Q` takes `Z`, i.e. wraps to 0 or to 2^width−1. `TC`=1 next cycle. `OVF` (increment) or `UNF` (decrement) sets.
- Carry or borrow, `saturate`=1: `Q` holds at max or 0. `TC`=1 next cycle. `OVF`/`UNF` sets.
- No `CO`: `Q` takes `Z`, `TC`=0.
- Masked steps: a step request in a cycle where `LD` or `CLR` is active is discarded. It sets no flag and produces no `TC`.

Sticky flags:
- `OVF`/`UNF` hold until `RST` or `CLR_FLAGS`.
- If a set event and `CLR_FLAGS` occur in the same cycle, set wins.

## Timing
- `Q`, `TC`, `OVF`, `UNF` are registers; all update one edge after the qualifying input cycle.
- `ZERO`/`MAX` are decoded combinationally from registered `Q`, so they are valid in the same cycle as `Q` and carry no input-to-output path.
- Throughput is one step per cycle, with no stalls and no handshake.
- All outputs after reset: `Q`=`rst_val`, `TC`=`OVF`=`UNF`=0; `ZERO`/`MAX` are consistent with `rst_val`.
- Reset mid-operation discards any pending step; no flag or `TC` results from it.
- Critical path: `Q` → `IncDecC` prefix tree → next-state mux. It scales as log2(width) for `speed`=`FAST`.

## Structure
- No new typedefs. `lau_pkg::speed_e` is reused.
- One sub-module instance: `IncDecC`, width = `width`.
- The next-state mux, flag logic and `ZERO`/`MAX` decode are local to `incdec_counter`.
- `MAX` is computed as the AND-reduce of `Q`. No extra adder.

## Test plan
All scenarios use `width`=4, `rst_val`=0 unless stated.
- Reset, then 20 `INC` cycles with `saturate`=0 → `Q` runs 1..15, then 0. `TC` pulses once, the cycle `Q` becomes 0. `OVF`=1 afterwards.
- With `saturate`=1: `LD` `D`=14, then 3 `INC` → `Q`=15, 15, 15. `TC` high on the 2nd and 3rd steps. `OVF`=1.
- `Q`=0, `DEC` with `saturate`=0 → `Q`=15, `UNF`=1, `TC`=1. Same with `saturate`=1 → `Q`=0, `UNF`=1.
- `Q`=7 with `INC`&`DEC` together → `Q`=7, no flags. `LD` `D`=3 with `INC` → `Q`=3. `CLR` with `DEC` at `Q`=0 → `Q`=0, `UNF` unchanged.
- `OVF`=1, then `CLR_FLAGS` → `OVF`=0 next cycle. `CLR_FLAGS` in the same cycle as an overflowing `INC` → `OVF` stays 1.
- `rst_val`=9: assert `RST` mid-count at `Q`=15 with `INC` held → `Q`=9, `TC`=`OVF`=0 next cycle. Random regression against a behavioural model for `width` ∈ {2, 8, 17}.
